// File: rtl/tri_bus_pkg.sv
// Shared types for the tri-state bus arbiter and its downstream driver stage.
// Latency: n/a (types, constants and a pure arbitration helper).
// Backpressure: n/a.
package tri_bus_pkg;

  // Data word width shared with the downstream driver pair.
  localparam int TRI_BUS_WIDTH = 8;

  typedef enum logic [1:0] {IDLE, OWN1, OWN2, TURN} arb_state_t;

  // Identifies which requester held the bus most recently.
  typedef enum logic {OWNER_1 = 1'b0, OWNER_2 = 1'b1} owner_t;

  // Round-robin pick: a lone request wins outright; a tie goes to the
  // requester that did not own the bus last.
  function automatic arb_state_t arbitrate(input logic r1, input logic r2,
                                           input owner_t last_owner);
    arb_state_t nxt;
    nxt = IDLE;
    if (r1 && r2) begin
      nxt = (last_owner == OWNER_2) ? OWN1 : OWN2;
    end else if (r1) begin
      nxt = OWN1;
    end else if (r2) begin
      nxt = OWN2;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/tri_bus_burst_cnt.sv
// Burst length counter: counts granted words, flags the MAX_BURST-th word.
// Latency: at_max is combinational from the count register; count updates on the clock edge.
// Backpressure: none; clr has priority over en.
module tri_bus_burst_cnt #(
  parameter int MAX_BURST = 16,
  localparam int CW = $clog2(MAX_BURST + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic at_max
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: clear on release, otherwise step once per captured word.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // High while the word being taken this cycle is the MAX_BURST-th of the burst.
  assign at_max = (cnt_q == CW'(MAX_BURST - 1));

endmodule

// File: rtl/tri_bus_arbiter.sv
// Two-requester round-robin arbiter owning the enables/data of a tri-state driver pair.
// Latency: req->gnt 1 cycle, gnt->ena/datin 1 cycle; optional TURN gap via TRI_BUS_ARB_TURNAROUND_EN.
// Backpressure: grants are held at most MAX_BURST cycles; dropping req releases the bus.
module tri_bus_arbiter
  import tri_bus_pkg::*;
#(
  parameter int WIDTH     = TRI_BUS_WIDTH,
  parameter int MAX_BURST = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req1,
  input  logic             req2,
  input  logic [WIDTH-1:0] din1,
  input  logic [WIDTH-1:0] din2,
  input  logic             last1,
  input  logic             last2,
  output logic             gnt1,
  output logic             gnt2,
  output logic             ena1,
  output logic             ena2,
  output logic [WIDTH-1:0] datin1,
  output logic [WIDTH-1:0] datin2,
  output logic             busy
);

  arb_state_t       state_q, state_d;
  owner_t           last_owner_q, last_owner_d;
  logic             ena1_q, ena1_d;
  logic             ena2_q, ena2_d;
  logic [WIDTH-1:0] datin1_q, datin1_d;
  logic [WIDTH-1:0] datin2_q, datin2_d;

  logic cnt_clr;
  logic cnt_en;
  logic at_max;
  logic own_is2;
  logic own_req;
  logic own_last;

  tri_bus_burst_cnt #(
    .MAX_BURST (MAX_BURST)
  ) u_burst_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (cnt_clr),
    .en     (cnt_en),
    .at_max (at_max)
  );

  // Next state, bus enables and captured words; the owner's enable is the
  // only qualifier, so non-owner data simply holds.
  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    ena1_d       = 1'b0;
    ena2_d       = 1'b0;
    datin1_d     = datin1_q;
    datin2_d     = datin2_q;
    cnt_clr      = 1'b0;
    cnt_en       = 1'b0;
    own_is2      = (state_q == OWN2);
    own_req      = own_is2 ? req2 : req1;
    own_last     = own_is2 ? last2 : last1;
    case (state_q)
      IDLE: begin
        state_d = arbitrate(req1, req2, last_owner_q);
      end
      OWN1, OWN2: begin
        // A dropped request means no word this cycle.
        if (own_req) begin
          cnt_en = 1'b1;
          if (own_is2) begin
            ena2_d   = 1'b1;
            datin2_d = din2;
          end else begin
            ena1_d   = 1'b1;
            datin1_d = din1;
          end
        end
        if (!own_req || own_last || at_max) begin
          cnt_clr      = 1'b1;
          last_owner_d = own_is2 ? OWNER_2 : OWNER_1;
`ifdef TRI_BUS_ARB_TURNAROUND_EN
          state_d = TURN;
`else
          // Immediate re-arbitration against the updated owner gives a
          // zero-gap handoff; enables still never overlap.
          state_d = arbitrate(req1, req2, last_owner_d);
`endif
        end
      end
      default: begin
        // TURN: one bus-idle cycle, then normal arbitration.
        state_d = arbitrate(req1, req2, last_owner_q);
      end
    endcase
  end

  // State, owner history and driver-stage registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_owner_q <= OWNER_2;
      ena1_q       <= 1'b0;
      ena2_q       <= 1'b0;
      datin1_q     <= '0;
      datin2_q     <= '0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      ena1_q       <= ena1_d;
      ena2_q       <= ena2_d;
      datin1_q     <= datin1_d;
      datin2_q     <= datin2_d;
    end
  end

  assign gnt1   = (state_q == OWN1);
  assign gnt2   = (state_q == OWN2);
  assign busy   = (state_q != IDLE);
  assign ena1   = ena1_q;
  assign ena2   = ena2_q;
  assign datin1 = datin1_q;
  assign datin2 = datin2_q;

endmodule

// File: tb/tb_tri_bus_arbiter.sv
// Bench for tri_bus_arbiter: directed scenarios plus a random run against a bus-ownership model.
// Latency: model tracks req->gnt and gnt->ena one cycle each.
// Backpressure: also bounds how long a holding requester waits for its grant.
module tb_tri_bus_arbiter;

  localparam int W    = 8;
  localparam int MAXB = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         req1 = 1'b0, req2 = 1'b0;
  logic [W-1:0] din1 = '0, din2 = '0;
  logic         last1 = 1'b0, last2 = 1'b0;
  logic         gnt1, gnt2, ena1, ena2, busy;
  logic [W-1:0] datin1, datin2;

  int n_tests = 0;
  int n_fail  = 0;
  bit cmp_en  = 1'b0;

  tri_bus_arbiter #(.WIDTH(W), .MAX_BURST(MAXB)) dut (
    .clk(clk), .rst_n(rst_n),
    .req1(req1), .req2(req2), .din1(din1), .din2(din2),
    .last1(last1), .last2(last2),
    .gnt1(gnt1), .gnt2(gnt2), .ena1(ena1), .ena2(ena2),
    .datin1(datin1), .datin2(datin2), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- ownership model ----------------
  int           m_owner = 0;   // 0: nobody, 1 or 2: current owner
  bit           m_turn  = 1'b0;
  int           m_words = 0;
  int           m_last  = 2;
  bit           m_ena1 = 1'b0, m_ena2 = 1'b0;
  logic [W-1:0] m_dat1 = '0, m_dat2 = '0;

  function automatic int pick(input bit r1, input bit r2, input int lastown);
    if (r1 && r2) return (lastown == 2) ? 1 : 2;
    if (r1) return 1;
    if (r2) return 2;
    return 0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_owner = 0; m_turn = 1'b0; m_words = 0; m_last = 2;
      m_ena1 = 1'b0; m_ena2 = 1'b0; m_dat1 = '0; m_dat2 = '0;
    end else begin
      bit rq, lst;
      m_ena1 = 1'b0;
      m_ena2 = 1'b0;
      if (m_owner != 0) begin
        rq  = (m_owner == 1) ? req1 : req2;
        lst = (m_owner == 1) ? last1 : last2;
        if (rq) begin
          m_words++;
          if (m_owner == 1) begin m_ena1 = 1'b1; m_dat1 = din1; end
          else              begin m_ena2 = 1'b1; m_dat2 = din2; end
        end
        if (!rq || lst || m_words >= MAXB) begin
          m_last  = m_owner;
          m_words = 0;
`ifdef TRI_BUS_ARB_TURNAROUND_EN
          m_owner = 0;
          m_turn  = 1'b1;
`else
          m_owner = pick(req1, req2, m_last);
`endif
        end
      end else begin
        m_turn  = 1'b0;
        m_owner = pick(req1, req2, m_last);
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  int w1 = 0, w2 = 0;

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("gnt1", 32'(gnt1), 32'(m_owner == 1));
      chk("gnt2", 32'(gnt2), 32'(m_owner == 2));
      chk("ena1", 32'(ena1), 32'(m_ena1));
      chk("ena2", 32'(ena2), 32'(m_ena2));
      chk("datin1", 32'(datin1), 32'(m_dat1));
      chk("datin2", 32'(datin2), 32'(m_dat2));
      chk("busy", 32'(busy), 32'((m_owner != 0) || m_turn));
      chk("ena_overlap", 32'(ena1 & ena2), 32'd0);
      chk("gnt_overlap", 32'(gnt1 & gnt2), 32'd0);
      // A requester holding req must be served within MAX_BURST+2 cycles.
      if (req1 && !gnt1) w1++;
      else begin
        if (gnt1 && w1 > 0) chk("wait1_bound", 32'(w1 > MAXB + 2), 32'd0);
        w1 = 0;
      end
      if (req2 && !gnt2) w2++;
      else begin
        if (gnt2 && w2 > 0) chk("wait2_bound", 32'(w2 > MAXB + 2), 32'd0);
        w2 = 0;
      end
    end
  end

  task automatic do_reset();
    req1 = 1'b0; req2 = 1'b0; last1 = 1'b0; last2 = 1'b0;
    din1 = '0; din2 = '0;
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int gap;
    int n;
    int wt;
    #1;
    do_reset();
    cmp_en = 1'b1;

    // Reset state.
    chk("rst_gnt1", 32'(gnt1), 32'd0);
    chk("rst_gnt2", 32'(gnt2), 32'd0);
    chk("rst_ena1", 32'(ena1), 32'd0);
    chk("rst_ena2", 32'(ena2), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_datin1", 32'(datin1), 32'd0);
    chk("rst_datin2", 32'(datin2), 32'd0);

    // Lone requester 1, three words, last on the third.
    req1 = 1'b1;
    step();
    chk("t1_gnt1_c1", 32'(gnt1), 32'd1);
    din1 = 8'h11; step();
    chk("t1_gnt1_c2", 32'(gnt1), 32'd1);
    chk("t1_ena1_11", 32'(ena1), 32'd1);
    chk("t1_datin1_11", 32'(datin1), 32'h11);
    din1 = 8'h22; step();
    chk("t1_gnt1_c3", 32'(gnt1), 32'd1);
    chk("t1_datin1_22", 32'(datin1), 32'h22);
    chk("t1_ena2_a", 32'(ena2), 32'd0);
    din1 = 8'h33; last1 = 1'b1; step();
    chk("t1_ena1_33", 32'(ena1), 32'd1);
    chk("t1_datin1_33", 32'(datin1), 32'h33);
    req1 = 1'b0; last1 = 1'b0; din1 = 8'h44; step();
    chk("t1_ena1_off", 32'(ena1), 32'd0);
    chk("t1_datin1_hold", 32'(datin1), 32'h33);
    chk("t1_ena2_b", 32'(ena2), 32'd0);

    // Simultaneous requests: 1 first, then 2, gap depends on turnaround.
    do_reset();
    req1 = 1'b1; req2 = 1'b1;
    step();
    chk("t2_gnt1_first", 32'(gnt1), 32'd1);
    chk("t2_gnt2_wait", 32'(gnt2), 32'd0);
    din1 = 8'hA1; last1 = 1'b1; step();
    chk("t2_ena1", 32'(ena1), 32'd1);
    req1 = 1'b0; last1 = 1'b0;
    gap = 0;
    for (int i = 0; i < 6 && !ena2; i++) begin
      if (gnt2) begin din2 = 8'hB2; last2 = 1'b1; end
      step();
      if (!ena1 && !ena2) gap++;
    end
    chk("t2_ena2_seen", 32'(ena2), 32'd1);
    chk("t2_datin2", 32'(datin2), 32'hB2);
`ifdef TRI_BUS_ARB_TURNAROUND_EN
    chk("t2_gap", 32'(gap), 32'd1);
`else
    chk("t2_gap", 32'(gap), 32'd0);
`endif

    // Forced release at MAX_BURST with requester 2 waiting.
    do_reset();
    req1 = 1'b1; req2 = 1'b1;
    step();
    n = 0;
    while (gnt1 && n < 20) begin
      din1 = 8'(8'h40 + n);
      n++;
      step();
    end
    chk("t3_burst_len", 32'(n), 32'(MAXB));
    wt = 0;
    while (!gnt2 && wt < 5) begin
      wt++;
      step();
    end
`ifdef TRI_BUS_ARB_TURNAROUND_EN
    chk("t3_handoff_wait", 32'(wt), 32'd1);
`else
    chk("t3_handoff_wait", 32'(wt), 32'd0);
`endif

    // Requester 2 drops req after two words.
    do_reset();
    req2 = 1'b1;
    step();
    din2 = 8'h55; step();
    din2 = 8'h66; step();
    chk("t4_datin2_66", 32'(datin2), 32'h66);
    req2 = 1'b0; din2 = 8'h77; step();
    chk("t4_ena2_off", 32'(ena2), 32'd0);
    chk("t4_datin2_hold", 32'(datin2), 32'h66);
    chk("t4_gnt2_off", 32'(gnt2), 32'd0);

    // Asynchronous reset in the middle of a burst.
    do_reset();
    req1 = 1'b1;
    step();
    din1 = 8'h99; step();
    chk("t5_datin1_99", 32'(datin1), 32'h99);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_gnt1", 32'(gnt1), 32'd0);
    chk("t5_rst_ena1", 32'(ena1), 32'd0);
    chk("t5_rst_datin1", 32'(datin1), 32'd0);
    chk("t5_rst_busy", 32'(busy), 32'd0);
    #1;
    rst_n = 1'b1;
    req2 = 1'b1;
    step();
    chk("t5_tie_gnt1", 32'(gnt1), 32'd1);
    chk("t5_tie_gnt2", 32'(gnt2), 32'd0);

    // Random traffic against the model.
    do_reset();
    for (int c = 0; c < 10000; c++) begin
      step();
      if ($urandom_range(0, 5) == 0) req1 = ~req1;
      if ($urandom_range(0, 5) == 0) req2 = ~req2;
      last1 = ($urandom_range(0, 3) == 0);
      last2 = ($urandom_range(0, 3) == 0);
      din1  = 8'($urandom);
      din2  = 8'($urandom);
    end
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
